// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, counter sizing.
package alu_seq_pkg;

  // Opcode values; anything at or above OP_RSVD_MIN is reserved.
  localparam int unsigned OP_ADD      = 0;
  localparam int unsigned OP_SUB      = 1;
  localparam int unsigned OP_AND      = 2;
  localparam int unsigned OP_OR       = 3;
  localparam int unsigned OP_XOR      = 4;
  localparam int unsigned OP_ANDN     = 5;
  localparam int unsigned OP_SLL      = 6;
  localparam int unsigned OP_SRL      = 7;
  localparam int unsigned OP_SRA      = 8;
  localparam int unsigned OP_ROL      = 9;
  localparam int unsigned OP_ROR      = 10;
  localparam int unsigned OP_MUL      = 11;
  localparam int unsigned OP_PASSA    = 12;
  localparam int unsigned OP_PASSB    = 13;
  localparam int unsigned OP_RSVD_MIN = 14;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Iteration counter must be able to hold the value W itself.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int OPERAND_WIDTH_DEFAULT = 16;
  localparam int CNT_W                 = cnt_width(OPERAND_WIDTH_DEFAULT);

endpackage

// File: rtl/alu_seq_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per clock, W clocks per product.
// product_o/done_o are valid combinationally during the last iteration so the
// caller can register the final product on the same edge the last bit is added.
module alu_mul_iter
  import alu_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] product_o,
  output logic           done_o
);

  localparam int CW = cnt_width(W);

  logic [2*W-1:0] mcand_q;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] acc_d;
  logic [W-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;
  logic           run_q;
  logic           last_iter;

  assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_iter = run_q && (cnt_q == CW'(W - 1));
  assign product_o = acc_d;
  assign done_o    = last_iter;

  // Load operands on start, then add/shift one multiplier bit per edge until W bits are done.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= {{W{1'b0}}, a_i};
      acc_q    <= '0;
      mplier_q <= b_i;
      cnt_q    <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (last_iter) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake, registered result/flags and an
// iterative multiplier. Single-cycle ops give one result per clock under no stall.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int OPERAND_WIDTH  = 16,
  parameter int NUM_OPERATIONS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OPERAND_WIDTH-1:0]  ALUsrcA,
  input  logic [OPERAND_WIDTH-1:0]  ALUsrcB,
  input  logic [NUM_OPERATIONS-1:0] Oper,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OPERAND_WIDTH-1:0]  ALUresult,
  output logic                      N,
  output logic                      Z,
  output logic                      P,
  output logic                      CO,
  output logic                      err,
  output logic                      busy
);

  localparam int W    = OPERAND_WIDTH;
  localparam int SH_W = $clog2(W);

  state_e         state_q;
  logic           out_valid_q;
  logic           busy_q;
  logic [W-1:0]   result_q;
  logic           n_q, z_q, p_q, co_q, err_q;

  logic           accept;
  logic           is_mul;
  logic           mul_done;
  logic [2*W-1:0] mul_product;
  logic           load_en;
  int unsigned    op_idx;
  logic [SH_W-1:0] shamt;
  logic [W:0]     sum_ext;
  logic [2*W-1:0] rot_l, rot_r;
  logic [W-1:0]   alu_res;
  logic           alu_co, alu_err;
  logic [W-1:0]   res_d;
  logic           n_d, z_d, p_d, co_d, err_d;

  assign op_idx   = 32'(Oper);
  assign is_mul   = (op_idx == OP_MUL);
  assign in_ready = rst && ((state_q == S_IDLE) || (state_q == S_DONE && out_ready));
  assign accept   = in_valid && in_ready;
  // A new result is captured on a single-cycle accept or when the multiplier finishes.
  assign load_en  = (accept && !is_mul) || (state_q == S_MUL && mul_done);

  alu_mul_iter #(
    .W(W)
  ) u_mul (
    .clk      (clk),
    .rst_n    (rst),
    .start_i  (accept && is_mul),
    .a_i      (ALUsrcA),
    .b_i      (ALUsrcB),
    .product_o(mul_product),
    .done_o   (mul_done)
  );

  // Combinational op evaluation and selection of the next result/flags.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    alu_res = '0;
    alu_co  = 1'b0;
    alu_err = 1'b0;
    sum_ext = '0;
    rot_l   = '0;
    rot_r   = '0;
    shamt   = ALUsrcB[SH_W-1:0];
    case (op_idx)
      OP_ADD: begin
        sum_ext = {1'b0, ALUsrcA} + {1'b0, ALUsrcB};
        alu_res = sum_ext[W-1:0];
        alu_co  = sum_ext[W];
      end
      OP_SUB: begin
        sum_ext = {1'b0, ALUsrcA} + {1'b0, ~ALUsrcB} + (W+1)'(1);
        alu_res = sum_ext[W-1:0];
        alu_co  = sum_ext[W];
      end
      OP_AND:   alu_res = ALUsrcA & ALUsrcB;
      OP_OR:    alu_res = ALUsrcA | ALUsrcB;
      OP_XOR:   alu_res = ALUsrcA ^ ALUsrcB;
      OP_ANDN:  alu_res = ALUsrcA & ~ALUsrcB;
      OP_SLL:   alu_res = ALUsrcA << shamt;
      OP_SRL:   alu_res = ALUsrcA >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(ALUsrcA) >>> shamt);
      OP_ROL: begin
        rot_l   = {ALUsrcA, ALUsrcA} << shamt;
        alu_res = rot_l[2*W-1:W];
      end
      OP_ROR: begin
        rot_r   = {ALUsrcA, ALUsrcA} >> shamt;
        alu_res = rot_r[W-1:0];
      end
      OP_MUL:   alu_res = '0;
      OP_PASSA: alu_res = ALUsrcA;
      OP_PASSB: alu_res = ALUsrcB;
      default:  alu_err = 1'b1;
    endcase

    if (state_q == S_MUL) begin
      res_d = mul_product[W-1:0];
      co_d  = |mul_product[2*W-1:W];
      err_d = 1'b0;
    end else begin
      res_d = alu_res;
      co_d  = alu_co;
      err_d = alu_err;
    end
    n_d = res_d[W-1];
    z_d = (res_d == '0);
    p_d = !n_d && !z_d;
  end

  // Result and flag registers; held whenever no new result is loaded (covers backpressure).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      p_q      <= 1'b0;
      co_q     <= 1'b0;
      err_q    <= 1'b0;
    end else if (load_en) begin
      result_q <= res_d;
      n_q      <= n_d;
      z_q      <= z_d;
      p_q      <= p_d;
      co_q     <= co_d;
      err_q    <= err_d;
    end
  end

  // Handshake FSM with registered out_valid and busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state_q <= S_MUL;
              busy_q  <= 1'b1;
            end else begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (mul_done) begin
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            if (accept && !is_mul) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
            end else if (accept) begin
              state_q     <= S_MUL;
              busy_q      <= 1'b1;
              out_valid_q <= 1'b0;
            end else begin
              state_q     <= S_IDLE;
              out_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign ALUresult = result_q;
  assign N         = n_q;
  assign Z         = z_q;
  assign P         = p_q;
  assign CO        = co_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus randomized ops against an
// arithmetic reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic [3:0]  oper = '0;
  logic        in_ready, out_valid, n, z, p, co, err, busy;
  logic [15:0] result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_seq #(
    .OPERAND_WIDTH (16),
    .NUM_OPERATIONS(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ALUsrcA  (a_in),
    .ALUsrcB  (b_in),
    .Oper     (oper),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ALUresult(result),
    .N        (n),
    .Z        (z),
    .P        (p),
    .CO       (co),
    .err      (err),
    .busy     (busy)
  );

  typedef struct packed {
    logic [15:0] res;
    logic        co;
    logic        err;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 16-bit values.
  function automatic exp_t model(input int op, input longint a, input longint b);
    exp_t   e;
    longint r;
    longint sa;
    int     sh;
    sh    = int'(b % 16);
    r     = 0;
    e.co  = 1'b0;
    e.err = 1'b0;
    case (op)
      0:  begin r = a + b;               e.co = (r >= 65536); end
      1:  begin r = a + (65535 - b) + 1; e.co = (r >= 65536); end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = a & (65535 - b);
      6:  r = a << sh;
      7:  r = a >> sh;
      8:  begin sa = (a >= 32768) ? a - 65536 : a; r = sa >>> sh; end
      9:  r = (sh == 0) ? a : ((a << sh) | (a >> (16 - sh)));
      10: r = (sh == 0) ? a : ((a >> sh) | (a << (16 - sh)));
      11: begin r = a * b; e.co = (r >= 65536); end
      12: r = a;
      13: r = b;
      default: begin r = 0; e.err = 1'b1; end
    endcase
    e.res = 16'(r & 65535);
    return e;
  endfunction

  function automatic logic [4:0] flags_of(input exp_t e);
    return {e.res[15], e.res == 16'h0, !e.res[15] && e.res != 16'h0, e.co, e.err};
  endfunction

  task automatic check_out(input string tag, input exp_t e);
    check({tag, "_res"}, 32'(result), 32'(e.res));
    check({tag, "_flags"}, 32'({n, z, p, co, err}), 32'(flags_of(e)));
  endtask

  // Present an op and return at posedge+1 after the accepting edge.
  task automatic send(input int op, input int a, input int b);
    bit done;
    done     = 1'b0;
    oper     = 4'(op);
    a_in     = 16'(a);
    b_in     = 16'(b);
    in_valid = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 0, 1);
  endtask

  // Count edges until out_valid; optionally verify the busy window on the way.
  task automatic wait_out(output int cycles, input bit chk_busy);
    cycles = 0;
    while (!out_valid && cycles < 64) begin
      if (chk_busy) begin
        check("mul_in_ready_low", 32'(in_ready), 0);
        check("mul_busy_high", 32'(busy), 1);
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!out_valid) check("result_timeout", 0, 1);
  endtask

  // Issue an op with out_ready low, check latency and model; leaves result held.
  task automatic run_op(input string tag, input int op, input int a, input int b, input int exp_lat);
    int cyc;
    out_ready = 1'b0;
    send(op, a, b);
    wait_out(cyc, op == 11);
    check({tag, "_latency"}, cyc, exp_lat);
    check_out(tag, model(op, a, b));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("valid_drop", 32'(out_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int op, a, b, hold;
    exp_t e;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_result", 32'(result), 0);
    check("rst_flags", 32'({n, z, p, co, err}), 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("idle_in_ready", 32'(in_ready), 1);

    // Directed cases
    run_op("add_wrap", 0, 16'hFFFF, 16'h0001, 0);
    check("add_wrap_const", 32'({result, n, z, p, co, err}), 32'({16'h0000, 5'b01010}));
    release_out();
    run_op("sub_neg", 1, 16'h0003, 16'h0005, 0);
    check("sub_neg_const", 32'({result, n, co}), 32'({16'hFFFE, 2'b10}));
    release_out();
    run_op("sra", 8, 16'h8000, 4, 0);
    check("sra_const", 32'(result), 32'h0000F800);
    release_out();
    run_op("rol", 9, 16'h8001, 1, 0);
    check("rol_const", 32'({result, co}), 32'({16'h0003, 1'b0}));
    release_out();
    run_op("mul_a", 11, 16'h0123, 16'h0010, 16);
    check("mul_a_const", 32'({result, co}), 32'({16'h1230, 1'b0}));
    check("mul_a_busy_fall", 32'(busy), 0);
    release_out();
    run_op("mul_b", 11, 16'h0100, 16'h0100, 16);
    check("mul_b_const", 32'({result, z, co}), 32'({16'h0000, 2'b11}));
    release_out();
    run_op("rsvd", 15, 16'h1234, 16'h0000, 0);
    check("rsvd_const", 32'({result, z, err}), 32'({16'h0000, 2'b11}));
    release_out();
    run_op("after_rsvd", 0, 2, 3, 0);
    check("after_rsvd_err", 32'(err), 0);
    release_out();

    // Backpressure then queued XOR with no bubble
    run_op("bp_add", 0, 5, 7, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_res", 32'(result), 32'h000C);
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_in_ready", 32'(in_ready), 0);
    end
    oper = 4'd4; a_in = 16'h00FF; b_in = 16'h0F0F;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_xor_valid", 32'(out_valid), 1);
    check("bp_xor_res", 32'(result), 32'h00000FF0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_xor_drop", 32'(out_valid), 0);

    // Back-to-back single-cycle burst, one result per clock
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      op = $urandom_range(0, 15);
      if (op == 11) op = 0;
      a = $urandom_range(0, 65535);
      b = $urandom_range(0, 65535);
      oper = 4'(op); a_in = 16'(a); b_in = 16'(b);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("burst_valid", 32'(out_valid), 1);
      check_out("burst", model(op, a, b));
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("burst_drop", 32'(out_valid), 0);

    // Randomized ops with random stall lengths
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 15);
      a = $urandom_range(0, 65535);
      b = $urandom_range(0, 65535);
      e = model(op, a, b);
      run_op("rand", op, a, b, (op == 11) ? 16 : 0);
      hold = $urandom_range(0, 3);
      for (int k = 0; k < hold; k++) begin
        @(posedge clk);
        #1;
        check_out("rand_hold", e);
        check("rand_hold_ready", 32'(in_ready), 0);
      end
      release_out();
    end

    // Reset in the middle of a multiply
    run_op("pre_rst", 0, 3, 4, 0);
    release_out();
    send(11, 16'h00FF, 16'h0101);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_result", 32'(result), 0);
    check("arst_flags", 32'({n, z, p, co, err}), 0);
    check("arst_ctrl", 32'({out_valid, busy, in_ready}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) cnt++;
    end
    check("post_rst_quiet", cnt, 0);
    run_op("post_rst_add", 0, 1, 1, 0);
    check("post_rst_add_const", 32'(result), 32'h0002);
    release_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential, parametrised successor to the combinational 16-bit ALU. It accepts operand pairs over a valid/ready handshake and registers result and flags. Single-cycle ops sustain one result per clock; an iterative shift-add multiplier takes OPERAND_WIDTH cycles. It sits between the decode/operand-fetch stage and writeback of the multi-cycle processor, so the datapath can stall on backpressure.

## Interface
- OPERAND_WIDTH, 16, data width; power of two, ≥4
- NUM_OPERATIONS, 4, opcode width in bits; ≥4
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept this cycle
- ALUsrcA  in  OPERAND_WIDTH  operand A
- ALUsrcB  in  OPERAND_WIDTH  operand B (low log2(OPERAND_WIDTH) bits = shift amount)
- Oper  in  NUM_OPERATIONS  opcode
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- ALUresult  out  OPERAND_WIDTH  registered result
- N, Z, P, CO  out  1 each  registered flags
- err  out  1  registered: opcode was reserved
- busy  out  1  high in MUL state

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 ANDN (A&~B), 6 SLL, 7 SRL, 8 SRA, 9 ROL, 10 ROR, 11 MUL (low half of A*B, unsigned), 12 PASSA, 13 PASSB, ≥14 reserved.
- Reserved opcode: result 0, flags from that result (Z=1, P=0, N=0), CO=0, err=1. err=0 for all defined ops.
- N = result MSB; Z = (result==0); P = !N && !Z.
- CO: ADD = carry out of A+B; SUB = carry out of A+~B+1 (1 = no borrow); MUL = 1 if upper half of full product nonzero; all other ops 0.
- All arithmetic is modulo 2^OPERAND_WIDTH. Shifts and rotates by 0 return A unchanged.
- Handshake: a transfer occurs on an edge where the valid and the corresponding ready are both high.
  - While out_valid && !out_ready: ALUresult, flags and err are held stable.
  - A producer may hold in_valid with changing data only while in_ready is low; data is sampled only on the accepting edge.
- State machine:
  - IDLE → (accept, single-cycle op) DONE; IDLE → (accept, MUL) MUL.
  - MUL → DONE when iteration count reaches OPERAND_WIDTH.
  - DONE → (out_ready, accept single-cycle op) DONE; DONE → (out_ready, accept MUL) MUL; DONE → (out_ready, no accept) IDLE.
- in_ready = rst && (state==IDLE || (state==DONE && out_ready)). Never high in MUL.
- Reset mid-operation: the in-flight op is discarded, no result is produced, and the state returns to IDLE.

## Timing
- Reset values: out_valid 0, ALUresult 0, N 0, Z 0, P 0, CO 0, err 0, busy 0, state IDLE, in_ready 0 while rst low.
- Single-cycle op accepted at edge k: out_valid high after edge k (latency 1).
- Back-to-back single-cycle ops with out_ready held high give 1 result per clock.
- MUL accepted at edge k: busy is high after edge k; one multiplier bit is processed per edge k+1..k+W; out_valid rises after edge k+W and busy falls at the same edge (W = OPERAND_WIDTH).
- out_valid falls after the edge where out_ready is high, unless a new single-cycle op is accepted on that same edge.

## Structure
- Shared package alu_seq_pkg holds:
  - opcode localparams (OP_ADD…OP_PASSB, OP_RSVD_MIN=14);
  - state encoding (S_IDLE, S_MUL, S_DONE);
  - CNT_W = log2(OPERAND_WIDTH)+1.
- Sub-module alu_mul_iter: iterative shift-add multiplier.
  - Inputs: start, a, b. Outputs: product (2W), done.
  - Holds the counter and accumulator. The top level owns the handshake, combinational ops and the flag logic.

## Test plan
- ADD 0xFFFF+0x0001, out_ready=1 → after 1 cycle ALUresult=0x0000, Z=1, CO=1, N=0, P=0, err=0.
- SUB 0x0003−0x0005 → 0xFFFE, N=1, CO=0. SRA 0x8000 by 4 → 0xF800. ROL 0x8001 by 1 → 0x0003, CO=0.
- MUL 0x0123×0x0010 → out_valid exactly 16 cycles after accept, result 0x1230, CO=0, and in_ready=0 throughout. MUL 0x0100×0x0100 → 0x0000, Z=1, CO=1.
- Backpressure: ADD 5+7 with out_ready low for 3 cycles → result 0x000C held stable and in_ready=0. Then out_ready high plus a queued XOR 0x00FF^0x0F0F → 0x0FF0 on the next cycle with no bubble.
- Reserved opcode 15, A=0x1234 → ALUresult=0, err=1, Z=1. A following ADD clears err to 0.
- Assert rst low 5 cycles into a MUL → all outputs 0 immediately (asynchronously). After release, out_valid stays 0 until a new accept, and a fresh ADD 1+1 → 0x0002 after 1 cycle.
